hazard_scoreboard: RTL

Parametrised load-use and RAW hazard unit for the pipelined datapath. It sits beside the decode stage and tracks destination registers of the last DEPTH issued instructions in an internal shift scoreboard, so it no longer needs rd/regWrite fed back from the downstream pipeline registers. Each cycle it decides whether the instruction in decode may issue. If not, it stalls PC and IF/ID and injects a bubble. With forwarding enabled, only load-use hazards stall; otherwise any RAW hazard stalls. Branch flush and stall statistics are handled here as well.

---
 rtl/hazard_scoreboard_if.sv | 33 +++
 rtl/hazard_scoreboard.sv | 124 ++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_if.sv
// Decode-side handshake bundle for the hazard scoreboard: decode-stage
// instruction attributes in, pipeline enables and stall statistics out.
interface hazard_scoreboard_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      instruction_i;
    logic             instr_valid_i;
    logic             uses_rt_i;
    logic [4:0]       dest_reg_i;
    logic             dest_write_i;
    logic             is_load_i;
    logic             flush_i;
    logic             pc_write_o;
    logic             decode_reg_write_o;
    logic             mux_control_o;
    logic [1:0]       hazard_stage_o;
    logic [2:0]       stall_run_o;
    logic [CNT_W-1:0] stall_total_o;

    modport master (
        output instruction_i, instr_valid_i, uses_rt_i, dest_reg_i,
               dest_write_i, is_load_i, flush_i,
        input  pc_write_o, decode_reg_write_o, mux_control_o,
               hazard_stage_o, stall_run_o, stall_total_o
    );

    modport slave (
        input  instruction_i, instr_valid_i, uses_rt_i, dest_reg_i,
               dest_write_i, is_load_i, flush_i,
        output pc_write_o, decode_reg_write_o, mux_control_o,
               hazard_stage_o, stall_run_o, stall_total_o
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Load-use / RAW hazard unit: shifts the destinations of the last DEPTH issued
// instructions and stalls decode while a source register is still in flight.
module hazard_scoreboard #(
    parameter int DEPTH      = 2,
    parameter int FORWARD_EN = 0,
    parameter int CNT_W      = 16
) (
    input logic               clk_i,
    input logic               rst_i,
    hazard_scoreboard_if.slave sb_if
);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] load_q, load_d;
    logic [4:0]       dest_q [DEPTH];
    logic [4:0]       dest_d [DEPTH];
    logic [2:0]       stall_run_q, stall_run_d;
    logic [CNT_W-1:0] stall_total_q, stall_total_d;

    logic [4:0]       rs_s, rt_s;
    logic [DEPTH-1:0] match_s, qual_s;
    logic [1:0]       stage_s;
    logic             stall_s, issue_s;
    logic             unused_instr_s;

    assign rs_s           = sb_if.instruction_i[25:21];
    assign rt_s           = sb_if.instruction_i[20:16];
    assign unused_instr_s = ^{sb_if.instruction_i[31:26], sb_if.instruction_i[15:0]};

    // Per-entry source match; with forwarding only a load still in EX can't be bypassed.
    always_comb begin
        match_s = '0;
        qual_s  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            match_s[k] = valid_q[k] && (dest_q[k] != 5'd0) &&
                         ((dest_q[k] == rs_s) || (sb_if.uses_rt_i && (dest_q[k] == rt_s)));
        end
        if (FORWARD_EN != 0) begin
            qual_s[0] = match_s[0] & load_q[0];
        end else begin
            qual_s = match_s;
        end
    end

    // Lowest matching entry index: scan from the oldest so the youngest wins.
    always_comb begin
        stage_s = 2'd0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            stage_s = qual_s[k] ? k[1:0] : stage_s;
        end
    end

    assign stall_s = ~rst_i & sb_if.instr_valid_i & ~sb_if.flush_i & (|qual_s);
    assign issue_s = sb_if.instr_valid_i & ~sb_if.flush_i & ~stall_s;

    // Pipeline enables with priority reset > flush > stall > normal.
    always_comb begin
        if (rst_i) begin
            sb_if.pc_write_o         = 1'b0;
            sb_if.decode_reg_write_o = 1'b0;
            sb_if.mux_control_o      = 1'b1;
        end else if (sb_if.flush_i) begin
            sb_if.pc_write_o         = 1'b1;
            sb_if.decode_reg_write_o = 1'b1;
            sb_if.mux_control_o      = 1'b1;
        end else if (stall_s) begin
            sb_if.pc_write_o         = 1'b0;
            sb_if.decode_reg_write_o = 1'b0;
            sb_if.mux_control_o      = 1'b1;
        end else begin
            sb_if.pc_write_o         = 1'b1;
            sb_if.decode_reg_write_o = 1'b1;
            sb_if.mux_control_o      = 1'b0;
        end
    end

    assign sb_if.hazard_stage_o = stall_s ? stage_s : 2'd0;
    assign sb_if.stall_run_o    = stall_run_q;
    assign sb_if.stall_total_o  = stall_total_q;

    // Scoreboard shift and saturating stall statistics.
    always_comb begin
        valid_d[0] = sb_if.dest_write_i & issue_s;
        dest_d[0]  = sb_if.dest_reg_i;
        load_d[0]  = sb_if.is_load_i & issue_s;
        for (int k = 1; k < DEPTH; k++) begin
            valid_d[k] = valid_q[k-1];
            dest_d[k]  = dest_q[k-1];
            load_d[k]  = load_q[k-1];
        end
        if (stall_s) begin
            stall_run_d = (stall_run_q == 3'd7) ? 3'd7 : (stall_run_q + 3'd1);
        end else begin
            stall_run_d = 3'd0;
        end
        if (stall_s && !(&stall_total_q)) begin
            stall_total_d = stall_total_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_total_d = stall_total_q;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q       <= '0;
            load_q        <= '0;
            stall_run_q   <= 3'd0;
            stall_total_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                dest_q[k] <= 5'd0;
            end
        end else begin
            valid_q       <= valid_d;
            load_q        <= load_d;
            stall_run_q   <= stall_run_d;
            stall_total_q <= stall_total_d;
            for (int k = 0; k < DEPTH; k++) begin
                dest_q[k] <= dest_d[k];
            end
        end
    end

endmodule
